// File: rtl/trisc_ir_decode.sv
// TRISC instruction register and opcode decoder: captures the fetched word,
// drives one-hot opcode lines, keeps Z/N flags, resolves jumps and latches halt.
module trisc_ir_decode #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              SysClock,
  input  logic              StartStop,
  input  logic              IrLoad,
  input  logic [ADDR_W+3:0] MemData,
  input  logic              FlagLoad,
  input  logic [DATA_W-1:0] AccData,
  output logic              LDA,
  output logic              STA,
  output logic              ADD,
  output logic              SUB,
  output logic              XOR,
  output logic              INC,
  output logic              CLR,
  output logic              JMP,
  output logic              JPZ,
  output logic              JPN,
  output logic              HLT,
  output logic [ADDR_W-1:0] Addr,
  output logic              ZFlag,
  output logic              NFlag,
  output logic              JumpTaken,
  output logic              IrValid,
  output logic              Illegal,
  output logic              Halted
);

  localparam int IR_W = ADDR_W + 4;

  typedef enum logic {
    RUN,
    HALT
  } state_t;

  state_t            state, state_nxt;
  logic [IR_W-1:0]   ir;
  logic              ir_valid;
  logic              z_q, n_q;
  logic              load_en;
  logic [3:0]        opcode;
  logic              undef_op;

  always_ff @(posedge SysClock or negedge StartStop) begin
    if (!StartStop) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load_en   = 1'b0;
    case (state)
      RUN: begin
        load_en = IrLoad;
        if (IrLoad && (MemData[IR_W-1 -: 4] == 4'b1111)) begin
          state_nxt = HALT;
        end
      end
      HALT: begin
        state_nxt = HALT;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  always_ff @(posedge SysClock or negedge StartStop) begin
    if (!StartStop) begin
      ir       <= '0;
      ir_valid <= 1'b0;
    end else if (load_en) begin
      ir       <= MemData;
      ir_valid <= 1'b1;
    end
  end

  // Flags track the accumulator even while halted.
  always_ff @(posedge SysClock or negedge StartStop) begin
    if (!StartStop) begin
      z_q <= 1'b0;
      n_q <= 1'b0;
    end else if (FlagLoad) begin
      z_q <= (AccData == '0);
      n_q <= AccData[DATA_W-1];
    end
  end

  assign opcode = ir[IR_W-1 -: 4];

  always_comb begin
    LDA      = 1'b0;
    STA      = 1'b0;
    ADD      = 1'b0;
    SUB      = 1'b0;
    XOR      = 1'b0;
    INC      = 1'b0;
    CLR      = 1'b0;
    JMP      = 1'b0;
    JPZ      = 1'b0;
    JPN      = 1'b0;
    HLT      = 1'b0;
    undef_op = 1'b0;
    if (ir_valid) begin
      case (opcode)
        4'b0000: LDA = 1'b1;
        4'b0001: STA = 1'b1;
        4'b0010: ADD = 1'b1;
        4'b0011: SUB = 1'b1;
        4'b0100: XOR = 1'b1;
        4'b0110: INC = 1'b1;
        4'b0111: CLR = 1'b1;
        4'b1000: JMP = 1'b1;
        4'b1001: JPZ = 1'b1;
        4'b1010: JPN = 1'b1;
        4'b1111: HLT = 1'b1;
        default: undef_op = 1'b1;
      endcase
    end
  end

  assign Addr      = ir[ADDR_W-1:0];
  assign ZFlag     = z_q;
  assign NFlag     = n_q;
  assign JumpTaken = JMP | (JPZ & z_q) | (JPN & n_q);
  assign IrValid   = ir_valid;
  assign Illegal   = undef_op;
  assign Halted    = (state == HALT);

endmodule

// File: tb/tb_trisc_ir_decode.sv
// Self-checking bench for trisc_ir_decode: vector table pushed through a
// scoreboard queue, plus hand-written reset and halt sequences.
module tb_trisc_ir_decode;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  localparam logic [10:0] O_NONE = 11'b000_0000_0000;
  localparam logic [10:0] O_LDA  = 11'b100_0000_0000;
  localparam logic [10:0] O_STA  = 11'b010_0000_0000;
  localparam logic [10:0] O_ADD  = 11'b001_0000_0000;
  localparam logic [10:0] O_SUB  = 11'b000_1000_0000;
  localparam logic [10:0] O_XOR  = 11'b000_0100_0000;
  localparam logic [10:0] O_INC  = 11'b000_0010_0000;
  localparam logic [10:0] O_CLR  = 11'b000_0001_0000;
  localparam logic [10:0] O_JMP  = 11'b000_0000_1000;
  localparam logic [10:0] O_JPZ  = 11'b000_0000_0100;
  localparam logic [10:0] O_JPN  = 11'b000_0000_0010;
  localparam logic [10:0] O_HLT  = 11'b000_0000_0001;

  typedef struct {
    logic              irl;
    logic [ADDR_W+3:0] md;
    logic              fl;
    logic [DATA_W-1:0] acc;
    logic [10:0]       lines;
    logic [ADDR_W-1:0] addr;
    logic              z;
    logic              n;
    logic              jt;
    logic              v;
    logic              ill;
    logic              h;
  } vec_t;

  logic              SysClock = 1'b0;
  logic              StartStop;
  logic              IrLoad;
  logic [ADDR_W+3:0] MemData;
  logic              FlagLoad;
  logic [DATA_W-1:0] AccData;
  logic LDA, STA, ADD, SUB, XOR, INC, CLR, JMP, JPZ, JPN, HLT;
  logic [ADDR_W-1:0] Addr;
  logic ZFlag, NFlag, JumpTaken, IrValid, Illegal, Halted;

  int unsigned checks = 0;
  int unsigned errors = 0;
  vec_t        sb[$];
  vec_t        vecs[21];

  trisc_ir_decode #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .SysClock (SysClock),
    .StartStop(StartStop),
    .IrLoad   (IrLoad),
    .MemData  (MemData),
    .FlagLoad (FlagLoad),
    .AccData  (AccData),
    .LDA      (LDA),
    .STA      (STA),
    .ADD      (ADD),
    .SUB      (SUB),
    .XOR      (XOR),
    .INC      (INC),
    .CLR      (CLR),
    .JMP      (JMP),
    .JPZ      (JPZ),
    .JPN      (JPN),
    .HLT      (HLT),
    .Addr     (Addr),
    .ZFlag    (ZFlag),
    .NFlag    (NFlag),
    .JumpTaken(JumpTaken),
    .IrValid  (IrValid),
    .Illegal  (Illegal),
    .Halted   (Halted)
  );

  always #5 SysClock = ~SysClock;

  function automatic logic [10:0] lines_now();
    return {LDA, STA, ADD, SUB, XOR, INC, CLR, JMP, JPZ, JPN, HLT};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input vec_t e);
    logic [10:0] l;
    l = lines_now();
    chk({tag, ".lines"}, 32'(l), 32'(e.lines));
    chk({tag, ".onehot"}, 32'($countones(l) <= 1), 32'd1);
    chk({tag, ".addr"}, 32'(Addr), 32'(e.addr));
    chk({tag, ".zn"}, {30'd0, ZFlag, NFlag}, {30'd0, e.z, e.n});
    chk({tag, ".jump"}, 32'(JumpTaken), 32'(e.jt));
    chk({tag, ".valid"}, 32'(IrValid), 32'(e.v));
    chk({tag, ".illegal"}, 32'(Illegal), 32'(e.ill));
    chk({tag, ".halted"}, 32'(Halted), 32'(e.h));
  endtask

  task automatic check_zero(input string tag);
    vec_t z;
    z = '{1'b0, '0, 1'b0, '0, O_NONE, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    check_outputs(tag, z);
  endtask

  // Drive a vector on the falling edge, queue its expectation, and compare it
  // just after the rising edge that consumes it.
  task automatic apply(input string tag, input vec_t v);
    vec_t e;
    @(negedge SysClock);
    IrLoad   = v.irl;
    MemData  = v.md;
    FlagLoad = v.fl;
    AccData  = v.acc;
    sb.push_back(v);
    @(posedge SysClock);
    #1;
    IrLoad   = 1'b0;
    FlagLoad = 1'b0;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      check_outputs(tag, e);
    end
  endtask

  initial begin
    vec_t idle;
    StartStop = 1'b0;
    IrLoad    = 1'b0;
    MemData   = '0;
    FlagLoad  = 1'b0;
    AccData   = '0;

    //          irl   md     fl    acc    lines   addr  z n jt v ill h
    vecs = '{
      '{1'b1, 8'h27, 1'b0, 8'h00, O_ADD,  4'h7, 0, 0, 0, 1, 0, 0},
      '{1'b1, 8'h6A, 1'b0, 8'h00, O_INC,  4'hA, 0, 0, 0, 1, 0, 0},
      '{1'b0, 8'h00, 1'b1, 8'h00, O_INC,  4'hA, 1, 0, 0, 1, 0, 0},
      '{1'b1, 8'h93, 1'b0, 8'h00, O_JPZ,  4'h3, 1, 0, 1, 1, 0, 0},
      '{1'b0, 8'h00, 1'b1, 8'h80, O_JPZ,  4'h3, 0, 1, 0, 1, 0, 0},
      '{1'b1, 8'hA3, 1'b0, 8'h00, O_JPN,  4'h3, 0, 1, 1, 1, 0, 0},
      '{1'b0, 8'h00, 1'b1, 8'h01, O_JPN,  4'h3, 0, 0, 0, 1, 0, 0},
      '{1'b1, 8'h95, 1'b1, 8'h00, O_JPZ,  4'h5, 1, 0, 1, 1, 0, 0},
      '{1'b1, 8'h53, 1'b0, 8'h00, O_NONE, 4'h3, 1, 0, 0, 1, 1, 0},
      '{1'b1, 8'h10, 1'b0, 8'h00, O_STA,  4'h0, 1, 0, 0, 1, 0, 0},
      '{1'b1, 8'h80, 1'b0, 8'h00, O_JMP,  4'h0, 1, 0, 1, 1, 0, 0},
      '{1'b1, 8'hB0, 1'b0, 8'h00, O_NONE, 4'h0, 1, 0, 0, 1, 1, 0},
      '{1'b1, 8'hE7, 1'b0, 8'h00, O_NONE, 4'h7, 1, 0, 0, 1, 1, 0},
      '{1'b1, 8'h00, 1'b0, 8'h00, O_LDA,  4'h0, 1, 0, 0, 1, 0, 0},
      '{1'b1, 8'h35, 1'b0, 8'h00, O_SUB,  4'h5, 1, 0, 0, 1, 0, 0},
      '{1'b1, 8'h4C, 1'b0, 8'h00, O_XOR,  4'hC, 1, 0, 0, 1, 0, 0},
      '{1'b1, 8'h71, 1'b0, 8'h00, O_CLR,  4'h1, 1, 0, 0, 1, 0, 0},
      '{1'b1, 8'hF0, 1'b0, 8'h00, O_HLT,  4'h0, 1, 0, 0, 1, 0, 1},
      '{1'b1, 8'h21, 1'b0, 8'h00, O_HLT,  4'h0, 1, 0, 0, 1, 0, 1},
      '{1'b0, 8'h00, 1'b1, 8'hFF, O_HLT,  4'h0, 0, 1, 0, 1, 0, 1},
      '{1'b1, 8'h93, 1'b1, 8'h00, O_HLT,  4'h0, 1, 0, 0, 1, 0, 1}
    };
    idle = '{1'b0, '0, 1'b0, '0, O_NONE, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    #2;
    check_zero("reset");
    @(negedge SysClock);
    StartStop = 1'b1;
    for (int i = 0; i < 10; i++) begin
      apply($sformatf("idle%0d", i), idle);
    end

    apply("pre_rst_load", '{1'b1, 8'h25, 1'b0, 8'h00, O_ADD, 4'h5, 0, 0, 0, 1, 0, 0});
    #2;
    StartStop = 1'b0;
    #1;
    check_zero("async_rst");
    @(negedge SysClock);
    StartStop = 1'b1;

    for (int i = 0; i < 21; i++) begin
      apply($sformatf("vec%0d", i), vecs[i]);
    end

    #2;
    StartStop = 1'b0;
    #1;
    check_zero("halt_rst");
    @(negedge SysClock);
    StartStop = 1'b1;
    apply("post_halt", '{1'b1, 8'h10, 1'b0, 8'h00, O_STA, 4'h0, 0, 0, 0, 1, 0, 0});

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
